// File: rtl/dmem_boot_loader.sv
// dmem_boot_loader: data memory shared between a boot-time loader port and the core, with core hold-in-reset sequencing
module dmem_boot_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 64,
  parameter int AUTO_INC = 0,
  parameter int RELEASE_CYC = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic ext_load_req,
  input  logic ext_valid,
  output logic ext_ready,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic ext_done,
  output logic cpu_reset,
  input  logic cpu_we,
  input  logic [DATA_W/8-1:0] cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [$clog2(DEPTH):0] load_count,
  output logic load_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam int NB = DATA_W / 8;
  localparam int RW = $clog2(RELEASE_CYC + 1);
  typedef enum logic [1:0] {BOOT, LOAD, RELEASE, RUN} state_t;
  state_t state, nextState;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] ptr;
  logic [RW-1:0] relCnt;
  logic [IW-1:0] ldIdx, cpuIdx;
  logic ldInRange, cpuInRange, beat, cpuWrite;
  always_comb begin
    ldInRange = AUTO_INC != 0 ? ptr < CW'(DEPTH) : 64'(ext_addr) < 64'(DEPTH) * 64'd4;
    ldIdx = AUTO_INC != 0 ? ptr[IW-1:0] : ext_addr[IW+1:2];
    cpuInRange = 64'(cpu_addr) < 64'(DEPTH) * 64'd4;
    cpuIdx = cpu_addr[IW+1:2];
    beat = ext_valid & ext_ready & ~reset;
    cpuWrite = cpu_we & cpuInRange & ~reset & (state == RUN);
    cpu_rdata = cpuInRange ? mem[cpuIdx] : '0;
    nextState = state == BOOT ? (ext_load_req ? LOAD : RUN)
      : state == LOAD ? (ext_done ? RELEASE : LOAD)
      : state == RELEASE ? (relCnt == RW'(RELEASE_CYC - 1) ? RUN : RELEASE)
      : (ext_load_req ? LOAD : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      cpu_reset <= 1'b1;
      ext_ready <= 1'b0;
      load_count <= '0;
      load_err <= 1'b0;
      ptr <= '0;
      relCnt <= '0;
    end else begin
      state <= nextState;
      cpu_reset <= nextState != RUN;
      ext_ready <= nextState == LOAD;
      relCnt <= state == RELEASE ? relCnt + 1'b1 : '0;
      if (nextState == LOAD && state != LOAD) begin
        ptr <= '0;
        load_count <= '0;
        load_err <= 1'b0;
      end else if (beat) begin
        if (ptr != CW'(DEPTH)) ptr <= ptr + 1'b1;
        if (ldInRange && load_count != CW'(DEPTH)) load_count <= load_count + 1'b1;
        if (!ldInRange) load_err <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (beat && ldInRange) mem[ldIdx] <= ext_wdata;
    else if (cpuWrite)
      for (int i = 0; i < NB; i++)
        if (cpu_be[i]) mem[cpuIdx][i*8 +: 8] <= cpu_wdata[i*8 +: 8];
  end
endmodule

// File: tb/tb_dmem_boot_loader.sv
// tb_dmem_boot_loader: randomized self-checking bench against a word-array reference model
module tb_dmem_boot_loader;
  localparam int D = 64;
  localparam int RC = 2;
  localparam int RC2 = 1;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, ext_load_req, ext_valid, ext_done, cpu_we, ext_ready, cpu_reset, load_err;
  logic [31:0] ext_addr, ext_wdata, cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0] cpu_be;
  logic [6:0] load_count;
  logic aReset, aLoadReq, aValid, aDone, aCpuWe, aReady, aCpuReset, aErr;
  logic [31:0] aAddr, aWdata, aCpuAddr, aCpuWdata, aRdata;
  logic [3:0] aCpuBe;
  logic [2:0] aCount;
  dmem_boot_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(D), .AUTO_INC(0), .RELEASE_CYC(RC)) dut (
    .clk(clk), .reset(reset), .ext_load_req(ext_load_req), .ext_valid(ext_valid), .ext_ready(ext_ready),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_done(ext_done), .cpu_reset(cpu_reset), .cpu_we(cpu_we),
    .cpu_be(cpu_be), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .load_count(load_count), .load_err(load_err));
  dmem_boot_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .AUTO_INC(1), .RELEASE_CYC(RC2)) dutAuto (
    .clk(clk), .reset(aReset), .ext_load_req(aLoadReq), .ext_valid(aValid), .ext_ready(aReady),
    .ext_addr(aAddr), .ext_wdata(aWdata), .ext_done(aDone), .cpu_reset(aCpuReset), .cpu_we(aCpuWe),
    .cpu_be(aCpuBe), .cpu_addr(aCpuAddr), .cpu_wdata(aCpuWdata), .cpu_rdata(aRdata),
    .load_count(aCount), .load_err(aErr));
  int checks = 0;
  int failures = 0;
  logic [31:0] mMem [D];
  bit mKnown [D];
  int mCount = 0;
  bit mErr = 0;
  logic [31:0] t1 [4];
  logic [31:0] t2 [6];
  logic [31:0] keep;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [31:0] a, input logic [31:0] d, input bit last);
    check("beat_ready", ext_ready, 1);
    ext_valid = 1; ext_addr = a; ext_wdata = d; ext_done = last;
    tick;
    ext_valid = 0; ext_done = 0;
    if (a < D * 4) begin
      mMem[a / 4] = d;
      mKnown[a / 4] = 1;
      if (mCount < D) mCount++;
    end else mErr = 1;
  endtask
  task automatic store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input bit apply);
    cpu_we = 1; cpu_addr = a; cpu_be = be; cpu_wdata = d;
    tick;
    cpu_we = 0;
    if (apply && a < D * 4) begin
      for (int i = 0; i < 4; i++) if (be[i]) mMem[a / 4][i*8 +: 8] = d[i*8 +: 8];
      if (be == 4'hF) mKnown[a / 4] = 1;
    end
  endtask
  task automatic rd(input string tag, input logic [31:0] a);
    cpu_addr = a;
    #1;
    if (a >= D * 4) check(tag, cpu_rdata, 0);
    else if (mKnown[a / 4]) check(tag, cpu_rdata, mMem[a / 4]);
  endtask
  task automatic release_seq(input string tag);
    for (int k = 1; k <= RC; k++) begin
      check({tag, "_hold"}, cpu_reset, 1);
      check({tag, "_noready"}, ext_ready, 0);
      tick;
    end
    check({tag, "_run"}, cpu_reset, 0);
  endtask
  task automatic random_core(input int n);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, D * 4 + 31);
      store(a, 4'($urandom), $urandom, 1);
      rd("rand_rd", a);
      rd("rand_rd2", $urandom_range(0, D * 4 + 15));
    end
  endtask
  initial begin
    {ext_load_req, ext_valid, ext_done, cpu_we} = '0;
    {ext_addr, ext_wdata, cpu_addr, cpu_wdata, cpu_be} = '0;
    {aLoadReq, aValid, aDone, aCpuWe, aAddr, aWdata, aCpuAddr, aCpuWdata, aCpuBe} = '0;
    reset = 1; aReset = 1;
    tick; tick;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_ready", ext_ready, 0);
    check("rst_count", load_count, 0);
    check("rst_err", load_err, 0);
    reset = 0; ext_load_req = 1;
    tick;
    ext_load_req = 0;
    check("t1_load_ready", ext_ready, 1);
    check("t1_load_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 4; i++) t1[i] = $urandom;
    for (int i = 0; i < 4; i++) beat(32'(i * 4), t1[i], i == 3);
    check("t1_count", load_count, 4);
    release_seq("t1");
    cpu_addr = 8; #1;
    check("t1_rd8", cpu_rdata, t1[2]);
    store(0, 4'hF, 32'h11223344, 1);
    store(0, 4'b0010, 32'hAABBCCDD, 1);
    cpu_addr = 1; #1;
    check("t3_byte_lane", cpu_rdata, 32'h1122CC44);
    random_core(30);
    ext_load_req = 1;
    store(32'h10, 4'hF, $urandom, 1);
    ext_load_req = 0;
    check("t4_cpu_reset", cpu_reset, 1);
    check("t4_ready", ext_ready, 1);
    check("t4_count_clr", load_count, 0);
    rd("t4_store_landed", 32'h10);
    mCount = 0; mErr = 0;
    store(32'h14, 4'hF, $urandom, 0);
    rd("load_store_ignored", 32'h14);
    beat(D * 4, $urandom, 0);
    check("t6_err", load_err, 1);
    check("t6_count", load_count, 0);
    rd("t6_no_alias", 0);
    for (int i = 0; i < D + 5; i++) begin
      if ($urandom_range(0, 3) == 0) tick;
      if ($urandom_range(0, 7) == 0) beat(32'(D * 4 + $urandom_range(0, 999) * 4), $urandom, 0);
      beat(32'(((i % D) * 4) + $urandom_range(0, 3)), $urandom, i == D + 4);
    end
    check("sat_count", load_count, D);
    check("sat_count_model", load_count, mCount);
    check("err_sticky_load", load_err, mErr);
    release_seq("full");
    check("err_sticky_run", load_err, 1);
    for (int i = 0; i < D; i++) rd("full_rd", 32'(i * 4 + $urandom_range(0, 3)));
    random_core(30);
    ext_load_req = 1;
    tick;
    ext_load_req = 0;
    mCount = 0; mErr = 0;
    check("t6_err_clear", load_err, 0);
    check("reload_count", load_count, 0);
    beat(32'h40, $urandom, 0);
    beat(32'h44, $urandom, 0);
    check("t5_count2", load_count, 2);
    keep = mMem[18];
    reset = 1; ext_valid = 1; ext_addr = 32'h48; ext_wdata = ~keep; ext_done = 1; ext_load_req = 1;
    tick;
    check("t5_cpu_reset", cpu_reset, 1);
    check("t5_ready", ext_ready, 0);
    check("t5_count", load_count, 0);
    check("t5_err", load_err, 0);
    reset = 0; ext_valid = 0; ext_done = 0; ext_load_req = 0;
    tick;
    check("t5_boot_to_run", cpu_reset, 0);
    rd("t5_keep0", 32'h40);
    rd("t5_keep1", 32'h44);
    cpu_addr = 32'h48; #1;
    check("t5_no_write_in_reset", cpu_rdata, keep);
    aReset = 0; aLoadReq = 1;
    @(posedge clk); #1;
    aLoadReq = 0;
    check("t2_ready", aReady, 1);
    for (int i = 0; i < 6; i++) begin
      t2[i] = $urandom;
      aValid = 1; aAddr = $urandom; aWdata = t2[i]; aDone = i == 5;
      @(posedge clk); #1;
    end
    aValid = 0; aDone = 0;
    check("t2_count", aCount, 4);
    check("t2_err", aErr, 1);
    check("t2_hold", aCpuReset, 1);
    @(posedge clk); #1;
    check("t2_run", aCpuReset, 0);
    for (int i = 0; i < 4; i++) begin
      aCpuAddr = 32'(i * 4); #1;
      check("t2_word", aRdata, t2[i]);
    end
    aCpuAddr = 32'h10; #1;
    check("t2_oor_rd", aRdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
